// File: rtl/macplus_kbd_pkg.sv
// Shared constants and state encoding for the Mac Plus keyboard responder.
package macplus_kbd_pkg;

  localparam logic [7:0] CMD_INQUIRY   = 8'h10;
  localparam logic [7:0] CMD_INSTANT   = 8'h14;
  localparam logic [7:0] CMD_MODEL     = 8'h16;
  localparam logic [7:0] CMD_TEST      = 8'h36;
  localparam logic [7:0] RSP_NULL      = 8'h7B;
  localparam logic [7:0] RSP_ACK       = 8'h7D;
  localparam logic [7:0] KEYPAD_PREFIX = 8'h79;
  localparam logic [6:0] KEY_NONE      = 7'h7f;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RX     = 3'd1,
    DECODE = 3'd2,
    WAIT   = 3'd3,
    TX     = 3'd4,
    TURN   = 3'd5
  } kbd_state_e;

  function automatic logic [7:0] event_byte(input logic up, input logic [6:0] code);
    return {up, code};
  endfunction

endpackage

// File: rtl/macplus_kbd_fifo.sv
// Synchronous key-event FIFO; a push is accepted on a full FIFO when a pop happens in the same cycle.
module macplus_kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] free
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0]   DEPTH_C   = AW1'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO  = AW1'(0);
  localparam logic [AW:0]   CNT_ONE   = AW1'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty = (count_r == CNT_ZERO);
  assign full  = (count_r == DEPTH_C);
  assign free  = DEPTH_C - count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests against occupancy
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Storage, pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/macplus_kbd_responder.sv
// Mac Plus keyboard end of the serial keyboard link: queues key events and answers host commands.
// Optional macro MACKBD_KEYPAD_PREFIX_EN: keypad events are queued as an 8'h79 prefix followed by the key byte.
module macplus_kbd_responder
  import macplus_kbd_pkg::*;
#(
  parameter int         HALF_CYC    = 1067,
  parameter int         INQ_TIMEOUT = 1625000,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] MODEL_ID    = 8'h0B
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [6:0] key_code,
  input  logic       key_up,
  input  logic       key_keypad,
  output logic       kbd_clk_o,
  input  logic       kbd_data_i,
  output logic       kbd_data_o,
  output logic       busy,
  output logic       overflow
);

  localparam int TW = $clog2((INQ_TIMEOUT > 2*HALF_CYC) ? INQ_TIMEOUT : 2*HALF_CYC) + 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] T_ZERO   = TW'(0);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [TW-1:0] HALF_END = TW'(HALF_CYC - 1);
  localparam logic [TW-1:0] TURN_END = TW'(2*HALF_CYC - 1);
  localparam logic [TW-1:0] WAIT_END = TW'(INQ_TIMEOUT - 1);

  kbd_state_e    state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    shift_r, shift_s;
  logic          clk_r, clk_s;
  logic          data_r, data_s;
  logic          busy_r, overflow_r;
  logic          sync1_r, sync2_r, prev_r;
  logic          tx_load_s;
  logic [7:0]    tx_byte_s;

  logic          pop_s, push_s, drop_s, ev_ok_s;
  logic [7:0]    push_data_s, fifo_head_s;
  logic          fifo_empty_s, fifo_full_s;
  logic [FW-1:0] fifo_free_s;

  assign kbd_clk_o  = clk_r;
  assign kbd_data_o = data_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign ev_ok_s    = key_valid && (key_code != KEY_NONE);

  macplus_kbd_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .free      (fifo_free_s)
  );

`ifdef MACKBD_KEYPAD_PREFIX_EN
  logic       pend_r;
  logic [7:0] pend_data_r;
  logic       pend_set_s;

  // Enqueue arbitration; the second half of a keypad pair owns the write port
  always_comb begin
    push_s      = 1'b0;
    push_data_s = event_byte(key_up, key_code);
    drop_s      = 1'b0;
    pend_set_s  = 1'b0;
    if (pend_r) begin
      push_s      = 1'b1;
      push_data_s = pend_data_r;
      drop_s      = ev_ok_s;
    end else if (ev_ok_s && key_keypad) begin
      if (fifo_free_s >= FW'(2)) begin
        push_s      = 1'b1;
        push_data_s = KEYPAD_PREFIX;
        pend_set_s  = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else if (ev_ok_s) begin
      if (!fifo_full_s || pop_s) push_s = 1'b1;
      else drop_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Holds the key byte that follows a queued prefix
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r      <= 1'b0;
      pend_data_r <= 8'h00;
    end else begin
      pend_r <= pend_set_s;
      if (pend_set_s) pend_data_r <= event_byte(key_up, key_code);
      else pend_data_r <= pend_data_r;
    end
  end
`else
  logic unused_keypad_s;
  assign unused_keypad_s = ^{key_keypad, fifo_free_s};

  // Enqueue arbitration, one entry per event
  always_comb begin
    push_s      = 1'b0;
    push_data_s = event_byte(key_up, key_code);
    drop_s      = 1'b0;
    if (ev_ok_s) begin
      if (!fifo_full_s || pop_s) push_s = 1'b1;
      else drop_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end
`endif

  // Link FSM next-state, shift and line-drive logic
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    clk_s     = clk_r;
    data_s    = data_r;
    pop_s     = 1'b0;
    tx_load_s = 1'b0;
    tx_byte_s = RSP_NULL;
    case (state_r)
      IDLE: begin
        clk_s  = 1'b1;
        data_s = 1'b1;
        if (!sync2_r && !prev_r) begin
          state_s   = RX;
          clk_s     = 1'b0;
          timer_s   = T_ZERO;
          bit_cnt_s = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      RX: begin
        if (timer_r != HALF_END) begin
          timer_s = timer_r + T_ONE;
        end else begin
          timer_s = T_ZERO;
          // Host data is sampled as the clock rises, MSB first
          if (!clk_r) begin
            clk_s   = 1'b1;
            shift_s = {shift_r[6:0], sync2_r};
          end else if (bit_cnt_r == 3'd7) begin
            state_s = DECODE;
          end else begin
            clk_s     = 1'b0;
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end
      end
      DECODE: begin
        case (shift_r)
          CMD_INQUIRY: begin
            if (!fifo_empty_s) begin
              pop_s     = 1'b1;
              tx_load_s = 1'b1;
              tx_byte_s = fifo_head_s;
            end else begin
              state_s = WAIT;
              timer_s = T_ZERO;
            end
          end
          CMD_INSTANT: begin
            tx_load_s = 1'b1;
            if (!fifo_empty_s) begin
              pop_s     = 1'b1;
              tx_byte_s = fifo_head_s;
            end else begin
              tx_byte_s = RSP_NULL;
            end
          end
          CMD_MODEL: begin
            tx_load_s = 1'b1;
            tx_byte_s = MODEL_ID;
          end
          CMD_TEST: begin
            tx_load_s = 1'b1;
            tx_byte_s = RSP_ACK;
          end
          default: state_s = IDLE;
        endcase
      end
      WAIT: begin
        // An event strobed on the timeout cycle defers the null by one cycle so it is returned instead
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          tx_load_s = 1'b1;
          tx_byte_s = fifo_head_s;
        end else if (timer_r != WAIT_END) begin
          timer_s = timer_r + T_ONE;
        end else if (!ev_ok_s) begin
          tx_load_s = 1'b1;
          tx_byte_s = RSP_NULL;
        end else begin
          timer_s = timer_r;
        end
      end
      TX: begin
        if (timer_r != HALF_END) begin
          timer_s = timer_r + T_ONE;
        end else begin
          timer_s = T_ZERO;
          if (!clk_r) begin
            clk_s = 1'b1;
          end else if (bit_cnt_r == 3'd7) begin
            state_s = TURN;
            data_s  = 1'b1;
          end else begin
            clk_s     = 1'b0;
            bit_cnt_s = bit_cnt_r + 3'd1;
            data_s    = shift_r[6];
            shift_s   = {shift_r[6:0], 1'b0};
          end
        end
      end
      TURN: begin
        if (timer_r == TURN_END) begin
          state_s = IDLE;
          timer_s = T_ZERO;
        end else begin
          timer_s = timer_r + T_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        clk_s   = 1'b1;
        data_s  = 1'b1;
      end
    endcase
    if (tx_load_s) begin
      state_s   = TX;
      shift_s   = tx_byte_s;
      clk_s     = 1'b0;
      data_s    = tx_byte_s[7];
      timer_s   = T_ZERO;
      bit_cnt_s = 3'd0;
    end else begin
      tx_byte_s = tx_byte_s;
    end
  end

  // FSM state, line drivers and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      timer_r    <= T_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      clk_r      <= 1'b1;
      data_r     <= 1'b1;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      clk_r      <= clk_s;
      data_r     <= data_s;
      busy_r     <= (state_s != IDLE);
      overflow_r <= overflow_r | drop_s;
    end
  end

  // Data-line synchroniser plus one cycle of history for start detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= kbd_data_i;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

endmodule

// File: tb/tb_macplus_kbd_responder.sv
// Scoreboard bench for macplus_kbd_responder: a host model sends commands and checks response bytes.
module tb_macplus_kbd_responder;

  localparam int HC    = 8;
  localparam int TO    = 400;
  localparam int LIM   = 4*HC + 20;
  localparam int RXLIM = 2*TO + 200;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_valid;
  logic [6:0] key_code;
  logic       key_up;
  logic       key_keypad;
  logic       kbd_clk_o;
  logic       kbd_data_i;
  logic       kbd_data_o;
  logic       busy;
  logic       overflow;
  logic       host_data;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  assign kbd_data_i = host_data & kbd_data_o;

  always #5 clk = ~clk;

  macplus_kbd_responder #(
    .HALF_CYC(HC), .INQ_TIMEOUT(TO), .FIFO_DEPTH(8), .MODEL_ID(8'h0B)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
    .key_up(key_up), .key_keypad(key_keypad), .kbd_clk_o(kbd_clk_o),
    .kbd_data_i(kbd_data_i), .kbd_data_o(kbd_data_o), .busy(busy), .overflow(overflow)
  );

  task automatic key_event(input logic [6:0] code, input logic up, input logic kp);
    @(negedge clk);
    key_valid = 1'b1; key_code = code; key_up = up; key_keypad = kp;
    @(negedge clk);
    key_valid = 1'b0; key_keypad = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    host_data = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      n = 0;
      while (kbd_clk_o !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
      if (n >= LIM) ok = 1'b0;
      host_data = cmd[i];
      n = 0;
      while (kbd_clk_o !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
      if (n >= LIM) ok = 1'b0;
    end
    host_data = 1'b1;
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok, output int wcyc);
    int n;
    ok = 1'b1; b = 8'h00; wcyc = 0;
    while (kbd_clk_o !== 1'b0 && wcyc < RXLIM) begin @(negedge clk); wcyc++; end
    if (wcyc >= RXLIM) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (kbd_clk_o !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
      if (n >= LIM) ok = 1'b0;
      n = 0;
      while (kbd_clk_o !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
      if (n >= LIM) ok = 1'b0;
      b = {b[6:0], kbd_data_i};
    end
    n = 0;
    while (busy !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) ok = 1'b0;
  endtask

  task automatic xact(input logic [7:0] cmd, output logic [7:0] b, output bit ok, output int wcyc);
    bit ok1, ok2;
    send_cmd(cmd, ok1);
    recv_byte(b, ok2, wcyc);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; host_data = 1'b1; key_valid = 1'b0; key_code = 7'h00;
    key_up = 1'b0; key_keypad = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({kbd_clk_o, kbd_data_o, busy, overflow} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_values got=%b exp=1100", {kbd_clk_o, kbd_data_o, busy, overflow});
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({kbd_clk_o, busy} !== 2'b10) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=10", {kbd_clk_o, busy});
    end
  endtask

  task automatic test_reset_mid_rx();
    int nfall = 0, n = 0;
    logic prev = 1'b1;
    logic [7:0] b; bit ok; int w;
    @(negedge clk);
    host_data = 1'b0;
    while (nfall < 4 && n < 20*HC) begin
      @(negedge clk); n++;
      if (prev === 1'b1 && kbd_clk_o === 1'b0) nfall++;
      prev = kbd_clk_o;
    end
    checks++;
    if (nfall != 4) begin failures++; $display("FAIL mid_rx_reach got=%0d exp=4", nfall); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({kbd_clk_o, kbd_data_o, busy} !== 3'b110) begin
      failures++;
      $display("FAIL mid_rx_reset got=%b exp=110", {kbd_clk_o, kbd_data_o, busy});
    end
    host_data = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h0B);
    xact(8'h16, b, ok, w);
    checks++;
    if (!ok || b !== exp_q.pop_front()) begin
      failures++; $display("FAIL model_after_reset got=%h ok=%0d exp=0b", b, ok);
    end
  endtask

  task automatic test_inquiry_instant();
    logic [7:0] b; bit ok; int w;
    key_event(7'h01, 1'b0, 1'b0);
    exp_q.push_back(8'h01);
    xact(8'h10, b, ok, w);
    checks++;
    if (!ok || b !== exp_q.pop_front()) begin
      failures++; $display("FAIL inquiry_press got=%h ok=%0d exp=01", b, ok);
    end
    key_event(7'h01, 1'b1, 1'b0);
    exp_q.push_back(8'h81);
    xact(8'h14, b, ok, w);
    checks++;
    if (!ok || b !== exp_q.pop_front()) begin
      failures++; $display("FAIL instant_release got=%h ok=%0d exp=81", b, ok);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b; bit ok, ok1; int w;
    exp_q.push_back(8'h7B);
    xact(8'h10, b, ok, w);
    checks++;
    if (!ok || b !== exp_q.pop_front()) begin
      failures++; $display("FAIL inquiry_null got=%h ok=%0d exp=7b", b, ok);
    end
    checks++;
    if (w < TO) begin failures++; $display("FAIL null_delay got=%0d exp>=%0d", w, TO); end
    send_cmd(8'h10, ok1);
    repeat (TO/2) @(negedge clk);
    checks++;
    if ({kbd_clk_o, busy} !== 2'b11) begin
      failures++; $display("FAIL wait_clk_high got=%b exp=11", {kbd_clk_o, busy});
    end
    key_event(7'h33, 1'b0, 1'b0);
    exp_q.push_back(8'h33);
    recv_byte(b, ok, w);
    checks++;
    if (!ok1 || !ok || b !== exp_q.pop_front()) begin
      failures++; $display("FAIL inquiry_late_event got=%h ok=%0d exp=33", b, ok);
    end
    checks++;
    if (w > 4) begin failures++; $display("FAIL late_event_delay got=%0d exp<=4", w); end
  endtask

  task automatic test_model_test_unknown();
    logic [7:0] b; bit ok; int w, n, lows;
    exp_q.push_back(8'h0B);
    exp_q.push_back(8'h7D);
    xact(8'h16, b, ok, w);
    checks++;
    if (!ok || b !== exp_q.pop_front()) begin
      failures++; $display("FAIL model got=%h ok=%0d exp=0b", b, ok);
    end
    xact(8'h36, b, ok, w);
    checks++;
    if (!ok || b !== exp_q.pop_front()) begin
      failures++; $display("FAIL test_cmd got=%h ok=%0d exp=7d", b, ok);
    end
    send_cmd(8'h55, ok);
    n = 0;
    while (busy !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
    checks++;
    if (!ok || n > HC + 3) begin
      failures++; $display("FAIL unknown_to_idle got=%0d cycles exp<=%0d", n, HC + 3);
    end
    lows = 0;
    repeat (4*HC) begin @(negedge clk); if (kbd_clk_o === 1'b0) lows++; end
    checks++;
    if (lows != 0) begin failures++; $display("FAIL unknown_no_reply got=%0d exp=0", lows); end
  endtask

  task automatic test_keypad();
    logic [7:0] b; bit ok; int w;
    key_event(7'h0d, 1'b0, 1'b1);
`ifdef MACKBD_KEYPAD_PREFIX_EN
    exp_q.push_back(8'h79);
    exp_q.push_back(8'h0d);
`else
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h7B);
`endif
    xact(8'h10, b, ok, w);
    checks++;
    if (!ok || b !== exp_q.pop_front()) begin
      failures++; $display("FAIL keypad_first got=%h ok=%0d", b, ok);
    end
    xact(8'h14, b, ok, w);
    checks++;
    if (!ok || b !== exp_q.pop_front()) begin
      failures++; $display("FAIL keypad_second got=%h ok=%0d", b, ok);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b; logic [7:0] e; bit ok; int w;
    key_event(7'h7f, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      key_event(7'(8'h20 + i), 1'b0, 1'b0);
      exp_q.push_back(8'h20 + 8'(i));
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_early got=%b exp=0", overflow); end
    key_event(7'h28, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", overflow); end
    exp_q.push_back(8'h7B);
    for (int i = 0; i < 9; i++) begin
      xact(8'h14, b, ok, w);
      e = exp_q.pop_front();
      checks++;
      if (!ok || b !== e) begin
        failures++; $display("FAIL overflow_drain%0d got=%h ok=%0d exp=%h", i, b, ok, e);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_rx();
    test_inquiry_instant();
    test_timeout();
    test_model_test_unknown();
    test_keypad();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/macplus_kbd_responder.md
Name: macplus_kbd_responder

Overview:
- Emulates the Mac Plus keyboard end of the keyboard serial link.
- Accepts already-translated Mac key codes from the companion keymap and queues them as key events.
- Drives the keyboard clock, shifts in host commands (Inquiry/Instant/Model/Test) and shifts out response bytes on the bidirectional open-drain data line.
- Sits between the companion keyboard path and the VIA keyboard pins of the Mac core.

Parameters:
- HALF_CYC, 1067: system clocks per half keyboard-clock period (~165 us at 6.5 MHz).
- INQ_TIMEOUT, 1625000: clocks an Inquiry waits for an event before answering null (~0.25 s).
- FIFO_DEPTH, 8: key event queue entries (power of 2).
- MODEL_ID, 8'h0B: byte returned for the Model command.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe: key event present.
- key_code  in  7  Mac key code from keymap; 7'h7f = unmapped.
- key_up  in  1  1 = release, 0 = press.
- key_keypad  in  1  event is a keypad key (used only with the optional feature).
- kbd_clk_o  out  1  keyboard clock to host; idles high.
- kbd_data_i  in  1  sampled data line (host or own drive).
- kbd_data_o  out  1  open-drain drive; 0 = pull low, 1 = release.
- busy  out  1  FSM not in IDLE.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset values: kbd_clk_o=1, kbd_data_o=1, busy=0, overflow=0. FIFO is emptied, timer=0, state=IDLE. Reset asserted mid-transfer aborts immediately and returns to these values.
- Event byte = {key_up, key_code}.
- Enqueue on key_valid when key_code != 7'h7f.
- A full FIFO drops the event and sets overflow. overflow clears only on reset.
- A simultaneous enqueue and dequeue on a full FIFO is accepted.
- kbd_data_i is synchronised with a 2-flop synchroniser before use.
- IDLE: kbd_data_i low for 2 consecutive synchronised cycles -> RX.
- RX: generate 8 clock pulses, each low HALF_CYC then high HALF_CYC. Sample data on each rising edge, MSB first. After the 8th high phase -> DECODE.
- DECODE (1 cycle):
  - 8'h10 Inquiry: FIFO non-empty -> load head and pop, go TX; empty -> WAIT with timer=0.
  - 8'h14 Instant: load head and pop, or load 8'h7B if empty -> TX.
  - 8'h16 Model: load MODEL_ID -> TX.
  - 8'h36 Test: load 8'h7D -> TX.
  - Any other value: no response -> IDLE.
- WAIT: timer increments each clock.
  - FIFO becomes non-empty -> load head and pop, go TX.
  - timer reaches INQ_TIMEOUT-1 -> load 8'h7B, go TX.
  - An event arriving on the timeout cycle wins over the null.
- TX: the host must have released data before TX starts; the block does not check this. For each bit, MSB first:
  - drive kbd_data_o = bit at the start of the clock-low phase;
  - hold for the low HALF_CYC and high HALF_CYC;
  - the host samples on the rising edge.
- After 8 bits, release kbd_data_o=1, wait 2*HALF_CYC turnaround -> IDLE.
- New key events are enqueued during any state. A popped byte is committed; it is not restored if reset hits mid-TX.

Optional Feature:
- Macro MACKBD_KEYPAD_PREFIX_EN.
- Defined: an event with key_keypad=1 enqueues two entries, 8'h79 then {key_up,key_code}, written on consecutive cycles.
  - Both entries are dropped (overflow set) if fewer than 2 entries are free.
  - Each entry is delivered by its own Inquiry/Instant.
- Not defined: key_keypad is ignored; every event is a single entry.

Decomposition:
- Package macplus_kbd_pkg:
  - command constants CMD_INQUIRY=8'h10, CMD_INSTANT=8'h14, CMD_MODEL=8'h16, CMD_TEST=8'h36;
  - RSP_NULL=8'h7B, RSP_ACK=8'h7D, KEYPAD_PREFIX=8'h79, KEY_NONE=7'h7f;
  - state enum {IDLE, RX, DECODE, WAIT, TX, TURN}.
- One sub-module: macplus_kbd_fifo (synchronous FIFO with full/empty/free-count; free-count is needed for the prefix feature).

Test Plan:
- Reset mid-RX (reset_n low during 4th clock pulse) -> kbd_clk_o=1, kbd_data_o=1, busy=0 within 0 cycles of assertion; next command works normally.
- key_code=7'h01, key_up=0, then host sends 8'h10 -> response bits 8'h01; key_code 7'h01 key_up=1 then Instant -> 8'h81.
- Empty FIFO, Inquiry -> kbd_clk_o stays high for INQ_TIMEOUT clocks, then response 8'h7B. Repeat with an event injected at half timeout -> that event is returned immediately.
- Model -> MODEL_ID 8'h0B; Test -> 8'h7D; command 8'h55 -> no response, return to IDLE after 8 clocks plus DECODE.
- 9 events without reads (DEPTH 8) -> overflow=1; 8 Instants return the first 8 codes in order; a 9th Instant returns 8'h7B. key_code=7'h7f is never enqueued.
- MACKBD_KEYPAD_PREFIX_EN: keypad event 7'h0d -> Inquiry returns 8'h79, next Inquiry returns 8'h0d. Feature off: the same stimulus returns only 8'h0d.
